// File: rtl/ddr2_line_bridge_if.sv
// ddr2_line_bridge_if: cache line port plus MIG app_* signals; slave = bridge, master = cache/MIG side
interface ddr2_line_bridge_if;
  logic [26:0]  ddr2_addr;
  logic         ddr2_enable;
  logic         ddr2_read;
  logic [127:0] to_ddr2_data;
  logic [127:0] ddr2_data;
  logic         ddr2_available;
  logic         ddr2_busy;
  logic         init_calib_complete;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         timeout_err;
  modport slave (
    input  ddr2_addr, ddr2_enable, ddr2_read, to_ddr2_data, init_calib_complete,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output ddr2_data, ddr2_available, ddr2_busy, app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_wren, app_wdf_end, timeout_err
  );
  modport master (
    output ddr2_addr, ddr2_enable, ddr2_read, to_ddr2_data, init_calib_complete,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  ddr2_data, ddr2_available, ddr2_busy, app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_wren, app_wdf_end, timeout_err
  );
endinterface

// File: rtl/ddr2_line_bridge.sv
// ddr2_line_bridge: cache line port to MIG app_* bridge with posted-write queue and read ordering.
// Optional read watchdog enabled by defining DDR2_BRIDGE_TIMEOUT_EN.
module ddr2_line_bridge #(
  parameter int WQ_DEPTH = 2,
  parameter int TIMEOUT  = 1023
) (
  input logic clk,
  input logic rst,
  ddr2_line_bridge_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, WR_ISSUE = 2'd1, RD_CMD = 2'd2, RD_WAIT = 2'd3;
  localparam int AW = $clog2(WQ_DEPTH);
  logic [1:0]    state;
  logic [22:0]   wq_line [WQ_DEPTH];
  logic [127:0]  wq_data [WQ_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic [22:0]   rd_line;
  logic read_pending, cmd_done, data_done;
  logic full, empty, push, rd_acc, cmd_fire, data_fire, wr_done, tmo_hit;
  logic unused_addr;
  assign unused_addr = ^bus.ddr2_addr[3:0];
  assign full  = cnt == (AW+1)'(WQ_DEPTH);
  assign empty = cnt == '0;
  assign bus.ddr2_busy = rst | ~bus.init_calib_complete | full | read_pending;
  assign push   = bus.ddr2_enable & ~bus.ddr2_read & ~bus.ddr2_busy;
  assign rd_acc = bus.ddr2_enable & bus.ddr2_read & ~bus.ddr2_busy;
  assign bus.app_en       = (state == WR_ISSUE & ~cmd_done) | state == RD_CMD;
  assign bus.app_wdf_wren = state == WR_ISSUE & ~data_done;
  assign bus.app_wdf_end  = bus.app_wdf_wren;
  assign bus.app_cmd      = state == RD_CMD ? 3'b001 : 3'b000;
  assign bus.app_addr     = {1'b0, (state == RD_CMD ? rd_line : wq_line[rp]), 3'b000};
  assign bus.app_wdf_data = wq_data[rp];
  assign cmd_fire  = bus.app_en & bus.app_rdy;
  assign data_fire = bus.app_wdf_wren & bus.app_wdf_rdy;
  assign wr_done   = state == WR_ISSUE & (cmd_done | cmd_fire) & (data_done | data_fire);
`ifdef DDR2_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1) > 10 ? $clog2(TIMEOUT + 1) : 10;
  logic [CW-1:0] tmo_cnt;
  logic tmo_err;
  // Counter idles at zero so it always starts from zero on entry to RD_CMD.
  assign tmo_hit = state[1] & tmo_cnt == CW'(TIMEOUT) & ~(state == RD_WAIT & bus.app_rd_data_valid);
  assign bus.timeout_err = tmo_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      tmo_cnt <= state[1] ? tmo_cnt + 1'b1 : '0;
      if (tmo_hit) tmo_err <= 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = TIMEOUT != 0;
  assign tmo_hit = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (push) begin
      wq_line[wp] <= bus.ddr2_addr[26:4];
      wq_data[wp] <= bus.to_ddr2_data;
    end
    if (rd_acc) rd_line <= bus.ddr2_addr[26:4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (wr_done) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, wr_done};
    end
  end
  // A push seen in IDLE moves straight to WR_ISSUE so the command appears the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      read_pending       <= 1'b0;
      cmd_done           <= 1'b0;
      data_done          <= 1'b0;
      bus.ddr2_available <= 1'b0;
      bus.ddr2_data      <= '0;
    end else begin
      bus.ddr2_available <= 1'b0;
      if (rd_acc) read_pending <= 1'b1;
      if (tmo_hit) begin
        bus.ddr2_data      <= '0;
        bus.ddr2_available <= 1'b1;
        read_pending       <= 1'b0;
        state              <= IDLE;
      end else begin
        case (state)
          IDLE: state <= (!empty || push) ? WR_ISSUE : (read_pending || rd_acc) ? RD_CMD : IDLE;
          WR_ISSUE: begin
            cmd_done  <= wr_done ? 1'b0 : cmd_done | cmd_fire;
            data_done <= wr_done ? 1'b0 : data_done | data_fire;
            if (wr_done) state <= IDLE;
          end
          RD_CMD: if (bus.app_rdy) state <= RD_WAIT;
          default: if (bus.app_rd_data_valid) begin
            bus.ddr2_data      <= bus.app_rd_data;
            bus.ddr2_available <= 1'b1;
            read_pending       <= 1'b0;
            state              <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ddr2_line_bridge.sv
// tb_ddr2_line_bridge: directed bench for ddr2_line_bridge with write/read scoreboards
module tb_ddr2_line_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ddr2_line_bridge_if b();
  ddr2_line_bridge #(.WQ_DEPTH(2), .TIMEOUT(1023)) dut (.clk(clk), .rst(rst), .bus(b));
  typedef struct {logic [26:0] addr; logic [127:0] data;} wr_t;
  wr_t wexp[$];
  logic [127:0] rexp[$];
  wr_t mon_e;
  int tests = 0, fails = 0, wr_cmds = 0, wr_datas = 0;
  int c0, d0, n;
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [26:0] line_addr(logic [26:0] a);
    return {1'b0, a[26:4], 3'b000};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(logic [26:0] a, logic [127:0] d, bit acc);
    b.ddr2_addr = a;
    b.to_ddr2_data = d;
    b.ddr2_read = 1'b0;
    b.ddr2_enable = 1'b1;
    if (acc) wexp.push_back('{line_addr(a), d});
    tick;
    b.ddr2_enable = 1'b0;
  endtask
  task automatic rd(logic [26:0] a, logic [127:0] d, bit exp);
    b.ddr2_addr = a;
    b.ddr2_read = 1'b1;
    b.ddr2_enable = 1'b1;
    if (exp) rexp.push_back(d);
    tick;
    b.ddr2_enable = 1'b0;
    b.ddr2_read = 1'b0;
  endtask
  always @(negedge clk) if (!rst) begin
    if (b.app_en && b.app_rdy && b.app_cmd == 3'b000) wr_cmds++;
    if (b.app_wdf_wren && b.app_wdf_rdy) begin
      wr_datas++;
      if (wexp.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        mon_e = wexp.pop_front();
        chk("wr_addr", b.app_addr, mon_e.addr);
        chk("wr_data", b.app_wdf_data, mon_e.data);
      end
    end
    if (b.ddr2_available) begin
      if (rexp.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_data", b.ddr2_data, rexp.pop_front());
    end
  end
  initial begin
    b.ddr2_addr = '0; b.ddr2_enable = 0; b.ddr2_read = 0; b.to_ddr2_data = '0;
    b.init_calib_complete = 0; b.app_rdy = 0; b.app_wdf_rdy = 0;
    b.app_rd_data = '0; b.app_rd_data_valid = 0;
    repeat (2) tick;
    chk("rst_app_en", b.app_en, 0);
    chk("rst_wren", b.app_wdf_wren, 0);
    chk("rst_avail", b.ddr2_available, 0);
    chk("rst_data", b.ddr2_data, 0);
    chk("rst_tmo", b.timeout_err, 0);
    chk("rst_busy", b.ddr2_busy, 1);
    rst = 0;
    tick;
    chk("calib_busy", b.ddr2_busy, 1);
    wr(27'd16352, 128'h5a, 0);
    repeat (3) begin
      chk("calib_no_app_en", b.app_en, 0);
      tick;
    end
    b.init_calib_complete = 1;
    #1;
    chk("calib_busy_clear", b.ddr2_busy, 0);
    b.app_rdy = 1; b.app_wdf_rdy = 1;
    wr(27'd12268, 128'd274, 1);
    chk("post_app_en", b.app_en, 1);
    chk("post_cmd", b.app_cmd, 3'b000);
    chk("post_addr", b.app_addr, line_addr(27'd12268));
    chk("post_wdf_data", b.app_wdf_data, 128'd274);
    chk("post_wdf_end", b.app_wdf_end, 1);
    chk("post_no_avail", b.ddr2_available, 0);
    tick;
    chk("post_done", b.app_en, 0);
    chk("post_one_pop", wr_datas, 1);
    b.app_wdf_rdy = 0;
    c0 = wr_cmds; d0 = wr_datas;
    wr(27'h1230, 128'hdead_beef_0001, 1);
    chk("split_en_c1", b.app_en, 1);
    chk("split_wren_c1", b.app_wdf_wren, 1);
    tick;
    chk("split_en_c2", b.app_en, 0);
    chk("split_wren_c2", b.app_wdf_wren, 1);
    tick;
    chk("split_wren_c3", b.app_wdf_wren, 1);
    tick;
    b.app_wdf_rdy = 1;
    chk("split_wren_c4", b.app_wdf_wren, 1);
    tick;
    chk("split_wren_c5", b.app_wdf_wren, 0);
    chk("split_en_c5", b.app_en, 0);
    chk("split_cmds", wr_cmds - c0, 1);
    chk("split_pops", wr_datas - d0, 1);
    b.app_rdy = 0;
    c0 = wr_cmds;
    wr(27'd9944, 128'd13897, 1);
    rd(27'd9944, 128'd13897, 1);
    repeat (4) begin
      chk("raw_hold", b.app_en && b.app_cmd == 3'b001, 0);
      tick;
    end
    b.app_rdy = 1;
    n = 0;
    while (!(b.app_en && b.app_cmd == 3'b001) && n < 20) begin
      tick;
      n++;
    end
    chk("raw_rd_issued", n < 20, 1);
    chk("raw_after_pop", wr_cmds - c0, 1);
    chk("raw_rd_addr", b.app_addr, line_addr(27'd9944));
    chk("raw_busy", b.ddr2_busy, 1);
    tick;
    b.app_rd_data = 128'd13897; b.app_rd_data_valid = 1;
    tick;
    b.app_rd_data_valid = 0;
    chk("raw_avail", b.ddr2_available, 1);
    chk("raw_data", b.ddr2_data, 128'd13897);
    tick;
    chk("raw_avail_pulse", b.ddr2_available, 0);
    chk("raw_sb_empty", rexp.size(), 0);
    b.app_rdy = 0; b.app_wdf_rdy = 0;
    c0 = wr_cmds;
    wr(27'h0100, 128'h11, 1);
    wr(27'h0210, 128'h22, 1);
    chk("full_busy", b.ddr2_busy, 1);
    wr(27'h0320, 128'h33, 0);
    b.app_rdy = 1; b.app_wdf_rdy = 1;
    repeat (8) tick;
    chk("full_cmds", wr_cmds - c0, 2);
    chk("full_sb_empty", wexp.size(), 0);
    rd(27'h4440, 128'h0, 0);
    tick;
    chk("rstw_busy", b.ddr2_busy, 1);
    rst = 1;
    tick;
    rst = 0;
    b.app_rd_data = 128'hbad; b.app_rd_data_valid = 1;
    tick;
    b.app_rd_data_valid = 0;
    chk("rstw_no_avail", b.ddr2_available, 0);
    chk("rstw_idle", b.ddr2_busy, 0);
    tick;
`ifdef DDR2_BRIDGE_TIMEOUT_EN
    rd(27'h7770, 128'h0, 1);
    n = 0;
    while (!b.ddr2_available && n < 1100) begin
      tick;
      n++;
    end
    chk("tmo_fired", n < 1100, 1);
    chk("tmo_data", b.ddr2_data, 0);
    chk("tmo_err", b.timeout_err, 1);
    tick;
    chk("tmo_err_sticky", b.timeout_err, 1);
    chk("tmo_idle", b.ddr2_busy, 0);
`else
    rd(27'h7770, 128'h0, 0);
    repeat (40) tick;
    chk("wait_no_avail", b.ddr2_available, 0);
    chk("wait_busy", b.ddr2_busy, 1);
    chk("wait_no_tmo", b.timeout_err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ddr2_line_bridge.md
Name: ddr2_line_bridge

Overview:
- Responder for the cache's line-refill/write-back port (ddr2_enable/ddr2_read/ddr2_addr/to_ddr2_data → ddr2_data/ddr2_available).
- Translates that port onto the MIG user (app_*) interface, so the cache runs against real DDR2 instead of the behavioural RAM model.
- Posts writes into a small queue and serialises reads behind them to preserve ordering.
- Adds ddr2_busy backpressure, which the cache samples before asserting ddr2_enable.

Parameters:
- WQ_DEPTH, 2: write-post queue entries (power of two, ≥2).
- TIMEOUT, 1023: read watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock (MIG ui_clk domain).
- rst  in  1  synchronous active-high reset.
- ddr2_addr  in  27  byte address from cache; bits [26:4] select a 128-bit line.
- ddr2_enable  in  1  one-cycle request strobe.
- ddr2_read  in  1  1 = read line, 0 = write line; qualified by ddr2_enable.
- to_ddr2_data  in  128  write line data.
- ddr2_data  out  128  read line data; valid while ddr2_available=1.
- ddr2_available  out  1  one-cycle pulse, read data returned.
- ddr2_busy  out  1  requests not accepted this cycle.
- init_calib_complete  in  1  MIG calibration done.
- app_addr  out  27  {1'b0, line[26:4], 3'b000}.
- app_cmd  out  3  3'b000 write, 3'b001 read.
- app_en  out  1  command valid.
- app_rdy  in  1  command accepted when app_en & app_rdy.
- app_wdf_data  out  128  write data.
- app_wdf_wren  out  1  write data valid.
- app_wdf_end  out  1  tied equal to app_wdf_wren (single-beat line).
- app_wdf_rdy  in  1  write data accepted when app_wdf_wren & app_wdf_rdy.
- app_rd_data  in  128  returned data.
- app_rd_data_valid  in  1  returned data valid.
- timeout_err  out  1  sticky watchdog flag (optional feature only).

Behaviour:
- Single clock; all state updates on posedge clk. rst is synchronous, active-high, and overrides all else.
- Reset values:
  - app_en=0, app_wdf_wren=0, ddr2_available=0, ddr2_data=0, timeout_err=0.
  - Queue empty, FSM in IDLE, any pending read discarded.
- ddr2_busy (combinational) = rst | ~init_calib_complete | queue_full | read_pending.
- ddr2_enable sampled while ddr2_busy=1 is dropped; no state change occurs.
- Write accept:
  - ddr2_enable & ~ddr2_read & ~busy pushes {ddr2_addr[26:4], to_ddr2_data} into the queue.
  - There is no response pulse to the cache.
  - Push and pop in the same cycle are allowed, including when the queue is full-1.
- Read accept:
  - ddr2_enable & ddr2_read & ~busy latches the line address and sets read_pending.
  - The read issues only after the queue is empty and no write is in flight (RAW ordering).
- FSM states: IDLE, WR_ISSUE, RD_CMD, RD_WAIT.
  - IDLE → WR_ISSUE when the queue is non-empty; queued writes take precedence over a pending read.
  - IDLE → RD_CMD when the queue is empty and read_pending=1.
  - WR_ISSUE:
    - Drives app_en (cmd=000) and app_wdf_wren from the queue head.
    - cmd_done and data_done flags latch app_rdy and app_wdf_rdy independently; each strobe drops once its own handshake completes.
    - When both are done: pop, clear the flags, then go to IDLE.
  - RD_CMD: drives app_en, cmd=001. On app_rdy → RD_WAIT.
  - RD_WAIT:
    - On app_rd_data_valid, register ddr2_data ← app_rd_data and pulse ddr2_available for exactly one cycle.
    - Clear read_pending and go to IDLE.
- app_rd_data_valid outside RD_WAIT is ignored (stale data after reset).
- Latency, idle bridge with app_rdy=1 and empty queue:
  - Read: enable at cycle 0, app_en at cycle 1, ddr2_available one cycle after app_rd_data_valid.
  - Write: app_en and app_wdf_wren at cycle 1.
- Reset mid-transaction abandons the in-flight MIG command. There is no replay.

Optional Feature:
- Macro: DDR2_BRIDGE_TIMEOUT_EN.
- When defined:
  - A 10-bit+ counter runs in RD_CMD/RD_WAIT and is cleared on entry to RD_CMD.
  - If it reaches TIMEOUT: ddr2_data=0, ddr2_available pulses once, timeout_err sets (sticky until rst), FSM goes to IDLE.
- When undefined: the counter is absent, timeout_err is tied to 0, and a read waits indefinitely.

Test Plan:
- Calibration gate: hold init_calib_complete=0 and pulse a write to 16352 → ddr2_busy=1, no app_en, queue unchanged; raise calib → busy=0.
- Posted write: write 12268 data 274 with app_rdy=app_wdf_rdy=1 → next cycle app_en=1, app_cmd=000, app_addr={1'b0,12268[26:4],3'b000}, app_wdf_data=274, app_wdf_end=1; no ddr2_available.
- Split handshake: app_rdy=1 but app_wdf_rdy=0 for 3 cycles → app_en drops after 1 cycle, app_wdf_wren held 4 cycles, single pop.
- RAW order: write 9944 data 13897, then immediately read 9944, with app_rdy low 5 cycles → read app_en only after the write pops; returning app_rd_data=13897 gives ddr2_data=13897 with a one-cycle ddr2_available.
- Queue full: WQ_DEPTH=2, app_rdy=0, three writes → third rejected (busy=1), exactly two write commands are issued later.
- Reset in RD_WAIT: rst for 1 cycle, then app_rd_data_valid → no ddr2_available. With DDR2_BRIDGE_TIMEOUT_EN and no valid data, a read yields ddr2_available with data 0 at TIMEOUT and timeout_err=1.
